// File: rtl/crossing_pkg.sv
// Shared types, bit positions and move-legality rule for the crossing input stage.
package crossing_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    ERR      = 2'd2,
    WAIT_REL = 2'd3
  } state_e;

  localparam int FARMER_B  = 3;
  localparam int FOX_B     = 2;
  localparam int CHICKEN_B = 1;
  localparam int SEED_B    = 0;

  // A move is legal when the farmer crosses and carries at most one passenger
  // that started on his bank. Bank safety is judged downstream, not here.
  function automatic logic is_legal_move(input logic [3:0] h, input logic [3:0] c);
    logic [3:0] diff;
    logic       ok;
    int         n_moved;
    diff    = h ^ c;
    ok      = diff[FARMER_B];
    n_moved = 0;
    for (int i = 0; i < FARMER_B; i++) begin
      if (diff[i]) begin
        n_moved++;
        if ((h[i] != h[FARMER_B]) || (c[i] != c[FARMER_B])) ok = 1'b0;
      end
    end
    if (n_moved > 1) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/crossing_input_debounce_bit.sv
// Single-bit synchronizer chain followed by a stability-counter debouncer.
module debounce_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign dout   = stable_q;

  // Shift the raw input in; count how long the synced value has disagreed.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    sync_d   = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d    = '0;
    stable_d = stable_q;
    if (synced != stable_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, counter and debounced value registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all state here is plain flops, so each gets an async clear; no memories.
    if (!reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/crossing_input.sv
// Input stage for the river-crossing FSM: debounces switches and GO, validates
// each proposed move and presents a held, registered position vector.
module crossing_input
  import crossing_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       sw,
  input  logic             btn_go,
  output logic             farmer,
  output logic             fox,
  output logic             chicken,
  output logic             seed,
  output logic             move_valid,
  output logic             move_err,
  output logic [CNT_W-1:0] move_count,
  output logic             busy
);

  logic [3:0]       db_sw;
  logic             db_go;
  logic             go_rise;
  logic             legal;

  state_e           state_q, state_d;
  logic [3:0]       held_q, held_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             go_prev_q, go_prev_d;

  for (genvar i = 0; i < 4; i++) begin : g_sw_db
    debounce_bit #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .din   (sw[i]),
      .dout  (db_sw[i])
    );
  end

  debounce_bit #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_go_db (
    .clk   (clk),
    .reset (reset),
    .din   (btn_go),
    .dout  (db_go)
  );

  assign go_rise = db_go & ~go_prev_q;
  assign legal   = is_legal_move(held_q, db_sw);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (go_rise) state_d = legal ? COMMIT : ERR;
      COMMIT:   state_d = WAIT_REL;
      ERR:      state_d = WAIT_REL;
      WAIT_REL: if (!db_go) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode: strobes and busy come straight from the state register.
  always_comb begin
    move_valid = (state_q == COMMIT);
    move_err   = (state_q == ERR);
    busy       = (state_q == WAIT_REL);
  end

  // Latch the candidate on the accepting edge so it is visible during COMMIT.
  always_comb begin
    go_prev_d = db_go;
    held_d    = held_q;
    count_d   = count_q;
    if ((state_q == IDLE) && go_rise && legal) begin
      held_d = db_sw;
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
    end
  end

  // Held vector, saturating move counter and GO edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_q    <= '0;
      count_q   <= '0;
      go_prev_q <= 1'b0;
    end else begin
      held_q    <= held_d;
      count_q   <= count_d;
      go_prev_q <= go_prev_d;
    end
  end

  assign farmer     = held_q[FARMER_B];
  assign fox        = held_q[FOX_B];
  assign chicken    = held_q[CHICKEN_B];
  assign seed       = held_q[SEED_B];
  assign move_count = count_q;

endmodule

// File: tb/tb_crossing_input.sv
// Directed bench for crossing_input: reset, legal/illegal moves, glitches,
// reset during COMMIT, the full solution sequence and counter saturation.
module tb_crossing_input;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       sw;
  logic             btn_go;
  logic             farmer, fox, chicken, seed;
  logic             move_valid, move_err, busy;
  logic [CNT_W-1:0] move_count;

  int checks   = 0;
  int failures = 0;
  int vld_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  crossing_input #(.SYNC_STAGES(2), .DB_CYCLES(16), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .btn_go     (btn_go),
    .farmer     (farmer),
    .fox        (fox),
    .chicken    (chicken),
    .seed       (seed),
    .move_valid (move_valid),
    .move_err   (move_err),
    .move_count (move_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (move_valid) vld_cnt++;
    if (move_err)   err_cnt++;
    if (move_valid && move_err) both_cnt++;
  end

  function automatic logic [3:0] held();
    return {farmer, fox, chicken, seed};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press GO for hold cycles, checking busy near the end, then release and settle.
  task automatic press(input string tag, input int hold);
    btn_go = 1'b1;
    tick(hold);
    check({tag, "_busy_hi"}, busy, 1'b1);
    btn_go = 1'b0;
    tick(30);
    check({tag, "_busy_lo"}, busy, 1'b0);
  endtask

  task automatic do_move(input string tag, input logic [3:0] val);
    sw = val;
    tick(20);
    press(tag, 30);
  endtask

  initial begin
    int v0, e0;
    bit found;
    logic [3:0] seq [7];
    seq = '{4'b1010, 4'b0010, 4'b1110, 4'b0100, 4'b1101, 4'b0101, 4'b1111};

    // Reset with switches and GO asserted: everything must read zero.
    reset  = 1'b0;
    sw     = 4'b1111;
    btn_go = 1'b1;
    tick(5);
    check("rst_held",  held(), 4'b0000);
    check("rst_valid", move_valid, 1'b0);
    check("rst_err",   move_err, 1'b0);
    check("rst_count", move_count, 0);
    check("rst_busy",  busy, 1'b0);
    btn_go = 1'b0;
    reset  = 1'b1;
    tick(40);
    check("post_rst_strobes", vld_cnt + err_cnt, 0);

    // Legal first move: farmer takes chicken across.
    sw = 4'b1010;
    tick(20);
    btn_go = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (move_valid) found = 1'b1;
    end
    check("m1_found",     found, 1'b1);
    check("m1_held_lat",  held(), 4'b1010);
    check("m1_count_lat", move_count, 1);
    tick(1);
    check("m1_one_cycle", move_valid, 1'b0);
    tick(10);
    check("m1_busy", busy, 1'b1);
    btn_go = 1'b0;
    tick(30);
    check("m1_idle", busy, 1'b0);
    check("m1_vld",  vld_cnt, 1);
    check("m1_err",  err_cnt, 0);

    // Illegal move 1010 -> 0111: fox was opposite farmer, two passengers moved.
    do_move("m2", 4'b0111);
    check("m2_err",   err_cnt, 1);
    check("m2_vld",   vld_cnt, 1);
    check("m2_held",  held(), 4'b1010);
    check("m2_count", move_count, 1);

    // 5-cycle GO glitch: no action.
    btn_go = 1'b1;
    tick(5);
    btn_go = 1'b0;
    tick(30);
    check("go_glitch", vld_cnt * 16 + err_cnt, 16 * 1 + 1);

    // 5-cycle switch glitch toward a legal 0010 never reaches the candidate.
    sw = 4'b0010;
    tick(5);
    sw = 4'b0111;
    tick(25);
    press("sw_glitch", 30);
    check("swg_err",  err_cnt, 2);
    check("swg_vld",  vld_cnt, 1);
    check("swg_held", held(), 4'b1010);

    // Reset asserted during COMMIT clears outputs asynchronously.
    sw = 4'b0010;
    tick(20);
    btn_go = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (move_valid) found = 1'b1;
    end
    check("rc_found", found, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rc_held",  held(), 4'b0000);
    check("rc_valid", move_valid, 1'b0);
    check("rc_count", move_count, 0);
    check("rc_busy",  busy, 1'b0);
    btn_go = 1'b0;
    sw     = 4'b0000;
    tick(3);
    reset = 1'b1;
    v0 = vld_cnt;
    e0 = err_cnt;
    tick(40);
    check("rc_quiet", (vld_cnt - v0) + (err_cnt - e0), 0);
    check("rc_held2", held(), 4'b0000);

    // Full solution from 0000.
    v0 = vld_cnt;
    for (int k = 0; k < 7; k++) begin
      do_move("sol", seq[k]);
      check("sol_held", held(), seq[k]);
    end
    check("sol_vld",   vld_cnt - v0, 7);
    check("sol_count", move_count, 7);

    // One more legal move: farmer returns alone; counter saturates.
    do_move("sat", 4'b0111);
    check("sat_vld",   vld_cnt - v0, 8);
    check("sat_held",  held(), 4'b0111);
    check("sat_count", move_count, 7);

    check("never_both", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
